// File: rtl/tcp_rx_reader_pkg.sv
// -----------------------------------------------------------------------------
// tcp_rx_reader_pkg
// Shared field layout, bus widths and FSM state encoding for the TCP receive
// reader. Notify words carry {closed, port, ip, len, sid}; meta words carry
// {len, sid}. Counters are one bit wider than the 16-bit length fields so that
// remaining-byte and received-byte arithmetic has headroom.
// -----------------------------------------------------------------------------
package tcp_rx_reader_pkg;

    localparam int NOTIFY_W   = 88;
    localparam int META_W     = 40;
    localparam int DATA_W     = 512;
    localparam int KEEP_W     = DATA_W / 8;
    localparam int CNT_W      = 17;

    localparam int SID_LSB    = 0;
    localparam int SID_W      = 16;
    localparam int LEN_LSB    = 16;
    localparam int LEN_W      = 16;
    localparam int IP_LSB     = 32;
    localparam int IP_W       = 32;
    localparam int PORT_LSB   = 64;
    localparam int PORT_W     = 16;
    localparam int CLOSED_BIT = 80;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_META = 2'd2,
        ST_DATA = 2'd3
    } rd_state_t;

    // Number of valid bytes in one beat.
    function automatic logic [6:0] keep_popcount(input logic [KEEP_W-1:0] keep);
        logic [6:0] n;
        n = 7'd0;
        for (int i = 0; i < KEEP_W; i++) begin
            n = n + {6'd0, keep[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/tcp_rx_reader_if.sv
// -----------------------------------------------------------------------------
// Handshake bundles used by tcp_rx_reader.
//   tcp_rx_meta_if : valid/ready/data metadata channel, WIDTH-bit payload
//                    m = producer, s = consumer
//   tcp_rx_axis_if : AXI4-Stream payload channel (tdata/tkeep/tlast)
//                    m = producer, s = consumer
// -----------------------------------------------------------------------------
interface tcp_rx_meta_if #(
    parameter int WIDTH = 40
) ();
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport m (output valid, output data, input ready);
    modport s (input valid, input data, output ready);
endinterface

interface tcp_rx_axis_if
    import tcp_rx_reader_pkg::*;
();
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;

    modport m (output tvalid, output tdata, output tkeep, output tlast, input tready);
    modport s (input tvalid, input tdata, input tkeep, input tlast, output tready);
endinterface

// File: rtl/tcp_rx_reader_bytecnt.sv
// -----------------------------------------------------------------------------
// tcp_rx_bytecnt
// Accumulates received bytes of one chunk.
//   aclk, areset : clock, asynchronous active-high reset
//   clr          : restart the count (start of a chunk)
//   beat         : a beat is handshaking this cycle
//   keep         : tkeep of the beat on the bus
//   total        : bytes received so far including the beat on the bus
// -----------------------------------------------------------------------------
module tcp_rx_bytecnt
    import tcp_rx_reader_pkg::*;
(
    input  logic              aclk,
    input  logic              areset,
    input  logic              clr,
    input  logic              beat,
    input  logic [KEEP_W-1:0] keep,
    output logic [CNT_W-1:0]  total
);

    logic [CNT_W-1:0] count_r;
    logic [CNT_W:0]   sum_s;

    // Running total including the current beat; saturates instead of wrapping
    // so an overlong stream can never alias back onto the expected length.
    always_comb begin
        sum_s = {1'b0, count_r} + {{(CNT_W-6){1'b0}}, keep_popcount(keep)};
        if (sum_s[CNT_W]) begin
            total = {CNT_W{1'b1}};
        end else begin
            total = sum_s[CNT_W-1:0];
        end
    end

    // Byte accumulator.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            count_r <= {CNT_W{1'b0}};
        end else if (beat) begin
            count_r <= total;
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/tcp_rx_reader.sv
// -----------------------------------------------------------------------------
// tcp_rx_reader
// Turns TCP notifies into read requests of at most MAX_RD_BYTES, then forwards
// the network's rx meta and payload to the user with zero latency, one
// transaction at a time.
//   aclk, areset    : clock, asynchronous active-high reset
//   s_tcp_notify    : notify in  {closed[80], port, ip, len[31:16], sid[15:0]}
//   m_tcp_rd_pkg    : read request out {len, sid}
//   s_tcp_rx_meta   : network rx meta in {len, sid}
//   s_axis_tcp_rx   : network payload in
//   m_rx_meta       : user meta out (pass-through)
//   m_axis_rx       : user payload out (pass-through)
//   stat_drop_cnt   : saturating count of dropped notifies (len 0 or closed)
//   stat_err        : sticky, received bytes differed from meta length
// -----------------------------------------------------------------------------
module tcp_rx_reader
    import tcp_rx_reader_pkg::*;
#(
    parameter int MAX_RD_BYTES = 4096
) (
    input  logic         aclk,
    input  logic         areset,
    tcp_rx_meta_if.s     s_tcp_notify,
    tcp_rx_meta_if.m     m_tcp_rd_pkg,
    tcp_rx_meta_if.s     s_tcp_rx_meta,
    tcp_rx_axis_if.s     s_axis_tcp_rx,
    tcp_rx_meta_if.m     m_rx_meta,
    tcp_rx_axis_if.m     m_axis_rx,
    output logic [31:0]  stat_drop_cnt,
    output logic         stat_err
);

    localparam logic [CNT_W-1:0] MAX_CHUNK = CNT_W'(MAX_RD_BYTES);

    rd_state_t        state_r;
    rd_state_t        state_s;
    logic [CNT_W-1:0] rem_r;
    logic [CNT_W-1:0] exp_r;
    logic [SID_W-1:0] sid_r;
    logic [31:0]      drop_cnt_r;
    logic             err_r;
    logic [CNT_W-1:0] chunk_s;
    logic [CNT_W-1:0] total_s;
    logic [LEN_W-1:0] notify_len_s;
    logic             notify_ok_s;
    logic             notify_hs_s;
    logic             rd_hs_s;
    logic             meta_hs_s;
    logic             beat_hs_s;
    logic             last_hs_s;
    logic             unused_notify_s;

    assign notify_len_s = s_tcp_notify.data[LEN_LSB +: LEN_W];
    assign notify_ok_s  = (notify_len_s != {LEN_W{1'b0}}) && !s_tcp_notify.data[CLOSED_BIT];

    // ip, port and reserved bits of the notify are not needed here.
    assign unused_notify_s = ^{s_tcp_notify.data[IP_LSB +: IP_W],
                               s_tcp_notify.data[PORT_LSB +: PORT_W],
                               s_tcp_notify.data[NOTIFY_W-1:CLOSED_BIT+1]};

    // Chunk never exceeds what remains, so rem - chunk cannot underflow.
    assign chunk_s = (rem_r > MAX_CHUNK) ? MAX_CHUNK : rem_r;

    // Handshakes are qualified by the gated valid/ready outputs, so each one
    // can only fire in its own state and never during reset.
    assign notify_hs_s = s_tcp_notify.valid && s_tcp_notify.ready;
    assign rd_hs_s     = m_tcp_rd_pkg.valid && m_tcp_rd_pkg.ready;
    assign meta_hs_s   = m_rx_meta.valid && m_rx_meta.ready;
    assign beat_hs_s   = m_axis_rx.tvalid && m_axis_rx.tready;
    assign last_hs_s   = beat_hs_s && s_axis_tcp_rx.tlast;

    assign m_tcp_rd_pkg.data = {8'd0, chunk_s[LEN_W-1:0], sid_r};
    assign m_rx_meta.data    = s_tcp_rx_meta.data;
    assign m_axis_rx.tdata   = s_axis_tcp_rx.tdata;
    assign m_axis_rx.tkeep   = s_axis_tcp_rx.tkeep;
    assign m_axis_rx.tlast   = s_axis_tcp_rx.tlast;

    assign stat_drop_cnt = drop_cnt_r;
    assign stat_err      = err_r;

    // FSM state register.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next state and handshake outputs; everything is forced low while
    // reset is asserted so outputs drop in the same cycle as the reset.
    always_comb begin
        state_s              = state_r;
        s_tcp_notify.ready   = 1'b0;
        m_tcp_rd_pkg.valid   = 1'b0;
        s_tcp_rx_meta.ready  = 1'b0;
        m_rx_meta.valid      = 1'b0;
        s_axis_tcp_rx.tready = 1'b0;
        m_axis_rx.tvalid     = 1'b0;
        if (areset) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    s_tcp_notify.ready = 1'b1;
                    if (s_tcp_notify.valid && notify_ok_s) begin
                        state_s = ST_REQ;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_REQ: begin
                    m_tcp_rd_pkg.valid = 1'b1;
                    if (m_tcp_rd_pkg.ready) begin
                        state_s = ST_META;
                    end else begin
                        state_s = ST_REQ;
                    end
                end
                ST_META: begin
                    s_tcp_rx_meta.ready = m_rx_meta.ready;
                    m_rx_meta.valid     = s_tcp_rx_meta.valid;
                    if (s_tcp_rx_meta.valid && m_rx_meta.ready) begin
                        state_s = ST_DATA;
                    end else begin
                        state_s = ST_META;
                    end
                end
                ST_DATA: begin
                    s_axis_tcp_rx.tready = m_axis_rx.tready;
                    m_axis_rx.tvalid     = s_axis_tcp_rx.tvalid;
                    if (s_axis_tcp_rx.tvalid && m_axis_rx.tready && s_axis_tcp_rx.tlast) begin
                        if (rem_r != {CNT_W{1'b0}}) begin
                            state_s = ST_REQ;
                        end else begin
                            state_s = ST_IDLE;
                        end
                    end else begin
                        state_s = ST_DATA;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // Transaction context: session id, bytes still to request, expected chunk size.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            sid_r <= {SID_W{1'b0}};
            rem_r <= {CNT_W{1'b0}};
            exp_r <= {CNT_W{1'b0}};
        end else if (notify_hs_s && notify_ok_s) begin
            sid_r <= s_tcp_notify.data[SID_LSB +: SID_W];
            rem_r <= {1'b0, notify_len_s};
        end else if (rd_hs_s) begin
            rem_r <= rem_r - chunk_s;
        end else if (meta_hs_s) begin
            exp_r <= {1'b0, s_tcp_rx_meta.data[LEN_LSB +: LEN_W]};
        end else begin
            sid_r <= sid_r;
        end
    end

    // Statistics: saturating drop counter and sticky length-mismatch flag.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            drop_cnt_r <= 32'd0;
            err_r      <= 1'b0;
        end else begin
            if (notify_hs_s && !notify_ok_s && (drop_cnt_r != 32'hFFFF_FFFF)) begin
                drop_cnt_r <= drop_cnt_r + 32'd1;
            end else begin
                drop_cnt_r <= drop_cnt_r;
            end
            if (last_hs_s && (total_s != exp_r)) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end

    tcp_rx_bytecnt u_bytecnt (
        .aclk   (aclk),
        .areset (areset),
        .clr    (meta_hs_s),
        .beat   (beat_hs_s),
        .keep   (s_axis_tcp_rx.tkeep),
        .total  (total_s)
    );

endmodule

// File: tb/tb_tcp_rx_reader.sv
// -----------------------------------------------------------------------------
// Self-checking bench for tcp_rx_reader. The bench plays the TCP stack (notify,
// rx meta, rx payload) and the user sink. A notify-level model derives the
// expected read requests, user meta and payload beats; monitors compare every
// handshake on the DUT outputs against it.
// -----------------------------------------------------------------------------
module tb_tcp_rx_reader;
    import tcp_rx_reader_pkg::*;

    localparam int MAX_RD = 4096;
    localparam int TMO    = 20000;
    localparam int N_RAND = 1000;

    typedef struct {
        logic [15:0] sid;
        logic [15:0] len;
        logic        closed;
    } notify_t;

    typedef struct {
        logic [15:0] sid;
        logic [15:0] rd_len;
        logic [15:0] meta_len;
        int          nbytes;
    } chunk_t;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic              last;
    } beat_t;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [31:0] stat_drop_cnt;
    logic        stat_err;

    int n_checks = 0;
    int n_pass   = 0;
    int stall_pct = 0;
    int rd_seen = 0;
    int user_beats = 0;
    int exp_drops = 0;
    bit mon_en = 1'b0;
    bit abort = 1'b0;
    bit scen_done = 1'b0;
    bit in_xfer = 1'b0;

    notify_t nq[$];
    chunk_t  exp_rd[$];
    chunk_t  exp_meta[$];
    chunk_t  net_q[$];
    beat_t   exp_beats[$];

    tcp_rx_meta_if #(.WIDTH(NOTIFY_W)) notify_if ();
    tcp_rx_meta_if #(.WIDTH(META_W))   rd_pkg_if ();
    tcp_rx_meta_if #(.WIDTH(META_W))   net_meta_if ();
    tcp_rx_meta_if #(.WIDTH(META_W))   user_meta_if ();
    tcp_rx_axis_if                     net_axis_if ();
    tcp_rx_axis_if                     user_axis_if ();

    tcp_rx_reader #(.MAX_RD_BYTES(MAX_RD)) dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_tcp_notify  (notify_if),
        .m_tcp_rd_pkg  (rd_pkg_if),
        .s_tcp_rx_meta (net_meta_if),
        .s_axis_tcp_rx (net_axis_if),
        .m_rx_meta     (user_meta_if),
        .m_axis_rx     (user_axis_if),
        .stat_drop_cnt (stat_drop_cnt),
        .stat_err      (stat_err)
    );

    always #5 aclk = ~aclk;

    task automatic check_val(input string tag, input logic [DATA_W-1:0] obs,
                             input logic [DATA_W-1:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic int rand_gap();
        if (stall_pct == 0) return 0;
        return ($urandom_range(99) < stall_pct) ? int'($urandom_range(3, 1)) : 0;
    endfunction

    // Reference model: a notify is either dropped or split into chunks of at
    // most MAX_RD bytes; each chunk yields one read request, one user meta and
    // the bytes the network returns, in order.
    task automatic add_notify(input logic [15:0] sid, input logic [15:0] len, input logic closed);
        notify_t n;
        chunk_t  ch;
        int      left;
        n.sid = sid;
        n.len = len;
        n.closed = closed;
        nq.push_back(n);
        if (len == 16'd0 || closed) begin
            exp_drops++;
        end else begin
            left = int'(len);
            while (left > 0) begin
                ch.sid      = sid;
                ch.rd_len   = 16'((left > MAX_RD) ? MAX_RD : left);
                ch.meta_len = ch.rd_len;
                ch.nbytes   = int'(ch.rd_len);
                exp_rd.push_back(ch);
                exp_meta.push_back(ch);
                net_q.push_back(ch);
                left -= int'(ch.rd_len);
            end
        end
    endtask

    task automatic drive_notifies();
        notify_t n;
        int t;
        while (nq.size() > 0 && !abort) begin
            n = nq.pop_front();
            repeat (rand_gap()) tick();
            notify_if.data  = {7'd0, n.closed, 16'($urandom()), 32'($urandom()), n.len, n.sid};
            notify_if.valid = 1'b1;
            t = 0;
            do begin @(negedge aclk); t++; end while (!notify_if.ready && t < TMO);
            if (!notify_if.ready) begin
                check_val("notify_timeout", {31'd0, notify_if.ready}, 1);
                abort = 1'b1;
            end
            tick();
            notify_if.valid = 1'b0;
        end
    endtask

    task automatic respond_network();
        chunk_t ch;
        beat_t  b;
        int t, left, base, k;
        base = rd_seen;
        k = 0;
        while (net_q.size() > 0 && !abort) begin
            ch = net_q.pop_front();
            t = 0;
            while (rd_seen <= base + k && t < TMO && !abort) begin tick(); t++; end
            if (rd_seen <= base + k) begin
                check_val("rd_pkg_timeout", rd_seen - base, k + 1);
                abort = 1'b1;
            end
            k++;
            repeat (rand_gap()) tick();
            net_meta_if.data  = {8'd0, ch.meta_len, ch.sid};
            net_meta_if.valid = 1'b1;
            t = 0;
            do begin @(negedge aclk); t++; end while (!net_meta_if.ready && t < TMO);
            if (!net_meta_if.ready) begin
                check_val("meta_timeout", {31'd0, net_meta_if.ready}, 1);
                abort = 1'b1;
            end
            tick();
            net_meta_if.valid = 1'b0;
            left = ch.nbytes;
            while (left > 0 && !abort) begin
                repeat (rand_gap()) tick();
                for (int w = 0; w < DATA_W / 32; w++) b.data[w*32 +: 32] = $urandom();
                b.keep = (left >= KEEP_W) ? {KEEP_W{1'b1}} : ((64'd1 << left) - 64'd1);
                b.last = (left <= KEEP_W);
                exp_beats.push_back(b);
                net_axis_if.tdata  = b.data;
                net_axis_if.tkeep  = b.keep;
                net_axis_if.tlast  = b.last;
                net_axis_if.tvalid = 1'b1;
                t = 0;
                do begin @(negedge aclk); t++; end while (!net_axis_if.tready && t < TMO);
                if (!net_axis_if.tready) begin
                    check_val("beat_timeout", {31'd0, net_axis_if.tready}, 1);
                    abort = 1'b1;
                end
                tick();
                net_axis_if.tvalid = 1'b0;
                left -= KEEP_W;
            end
        end
    endtask

    task automatic drive_sinks();
        while (!scen_done) begin
            rd_pkg_if.ready     = ($urandom_range(99) >= stall_pct);
            user_meta_if.ready  = ($urandom_range(99) >= stall_pct);
            user_axis_if.tready = ($urandom_range(99) >= stall_pct);
            tick();
        end
        rd_pkg_if.ready     = 1'b0;
        user_meta_if.ready  = 1'b0;
        user_axis_if.tready = 1'b0;
    endtask

    task automatic run_scenario();
        scen_done = 1'b0;
        fork
            begin
                fork
                    drive_notifies();
                    respond_network();
                join
                scen_done = 1'b1;
            end
            drive_sinks();
        join
        repeat (4) tick();
        check_val("rd_pkg_outstanding", exp_rd.size(), 0);
        check_val("meta_outstanding", exp_meta.size(), 0);
        check_val("beats_outstanding", exp_beats.size(), 0);
        check_val("back_to_idle", {31'd0, notify_if.ready}, 1);
        nq.delete(); exp_rd.delete(); exp_meta.delete(); net_q.delete(); exp_beats.delete();
    endtask

    // Output monitors: every handshake on a DUT output is matched to the model.
    initial begin
        chunk_t ch;
        beat_t  b;
        forever begin
            @(negedge aclk);
            if (mon_en) begin
                if (rd_pkg_if.valid && rd_pkg_if.ready) begin
                    rd_seen++;
                    check_val("rd_while_busy", {31'd0, in_xfer}, 0);
                    in_xfer = 1'b1;
                    check_val("rd_pkg_expected", exp_rd.size() > 0, 1);
                    if (exp_rd.size() > 0) begin
                        ch = exp_rd.pop_front();
                        check_val("rd_pkg", rd_pkg_if.data, {8'd0, ch.rd_len, ch.sid});
                    end
                end
                if (user_meta_if.valid && user_meta_if.ready) begin
                    check_val("user_meta_expected", exp_meta.size() > 0, 1);
                    if (exp_meta.size() > 0) begin
                        ch = exp_meta.pop_front();
                        check_val("user_meta", user_meta_if.data, {8'd0, ch.meta_len, ch.sid});
                    end
                end
                if (user_axis_if.tvalid && user_axis_if.tready) begin
                    user_beats++;
                    check_val("beat_expected", exp_beats.size() > 0, 1);
                    if (exp_beats.size() > 0) begin
                        b = exp_beats.pop_front();
                        check_val("beat_data", user_axis_if.tdata, b.data);
                        check_val("beat_keep", user_axis_if.tkeep, b.keep);
                        check_val("beat_last", {31'd0, user_axis_if.tlast}, {31'd0, b.last});
                        if (b.last) in_xfer = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rs, ub, r;
        logic [15:0] len;
        notify_if.valid = 1'b0;  notify_if.data = '0;
        net_meta_if.valid = 1'b0; net_meta_if.data = '0;
        net_axis_if.tvalid = 1'b0; net_axis_if.tdata = '0;
        net_axis_if.tkeep = '0; net_axis_if.tlast = 1'b0;
        rd_pkg_if.ready = 1'b0; user_meta_if.ready = 1'b0; user_axis_if.tready = 1'b0;

        areset = 1'b1;
        repeat (3) tick();
        check_val("rst_notify_ready", {31'd0, notify_if.ready}, 0);
        check_val("rst_rd_valid", {31'd0, rd_pkg_if.valid}, 0);
        check_val("rst_drop_cnt", stat_drop_cnt, 0);
        check_val("rst_err", {31'd0, stat_err}, 0);
        areset = 1'b0;
        tick();
        check_val("ready_after_reset", {31'd0, notify_if.ready}, 1);
        mon_en = 1'b1;

        // Single small notify: one request, two beats (64 + 36 bytes).
        stall_pct = 0;
        add_notify(16'd5, 16'd100, 1'b0);
        ub = user_beats;
        run_scenario();
        check_val("req029_beats", user_beats - ub, 2);
        check_val("req029_err", {31'd0, stat_err}, 0);

        // Large notify split into 4096/4096/1808 with stalls.
        stall_pct = 30;
        rs = rd_seen;
        add_notify(16'd9, 16'd10000, 1'b0);
        run_scenario();
        check_val("req030_rd_count", rd_seen - rs, 3);

        // Zero-length and closed notifies are dropped.
        rs = rd_seen;
        add_notify(16'd3, 16'd0, 1'b0);
        add_notify(16'd4, 16'd50, 1'b1);
        run_scenario();
        check_val("req031_no_rd", rd_seen - rs, 0);
        check_val("req031_drops", stat_drop_cnt, exp_drops);

        // Meta claims 128 bytes, network delivers a single full beat.
        stall_pct = 0;
        add_notify(16'd11, 16'd128, 1'b0);
        net_q[net_q.size()-1].nbytes = 64;
        run_scenario();
        check_val("req032_err", {31'd0, stat_err}, 1);

        // Reset during the second beat of a transfer.
        mon_en = 1'b0;
        notify_if.data = {7'd0, 1'b0, 16'd0, 32'd0, 16'd200, 16'd7};
        notify_if.valid = 1'b1;
        rd_pkg_if.ready = 1'b1; user_meta_if.ready = 1'b1; user_axis_if.tready = 1'b1;
        tick();
        notify_if.valid = 1'b0;
        tick();
        net_meta_if.data = {8'd0, 16'd200, 16'd7};
        net_meta_if.valid = 1'b1;
        tick();
        net_meta_if.valid = 1'b0;
        net_axis_if.tdata = {16{32'hA5A5_0001}};
        net_axis_if.tkeep = {KEEP_W{1'b1}};
        net_axis_if.tlast = 1'b0;
        net_axis_if.tvalid = 1'b1;
        tick();
        net_axis_if.tdata = {16{32'h5A5A_0002}};
        #1;
        check_val("req034_beat2_fwd", {31'd0, user_axis_if.tvalid}, 1);
        check_val("req034_err_sticky", {31'd0, stat_err}, 1);
        areset = 1'b1;
        #1;
        check_val("req034_user_tvalid", {31'd0, user_axis_if.tvalid}, 0);
        check_val("req034_net_tready", {31'd0, net_axis_if.tready}, 0);
        check_val("req034_notify_ready", {31'd0, notify_if.ready}, 0);
        check_val("req034_rd_valid", {31'd0, rd_pkg_if.valid}, 0);
        check_val("req034_meta_valid", {31'd0, user_meta_if.valid}, 0);
        check_val("req034_meta_ready", {31'd0, net_meta_if.ready}, 0);
        check_val("req034_drop_cnt", stat_drop_cnt, 0);
        check_val("req034_err", {31'd0, stat_err}, 0);
        tick();
        areset = 1'b0;
        tick();
        check_val("req034_no_partial", {31'd0, user_axis_if.tvalid}, 0);
        check_val("req034_ready_again", {31'd0, notify_if.ready}, 1);
        net_axis_if.tvalid = 1'b0;
        rd_pkg_if.ready = 1'b0; user_meta_if.ready = 1'b0; user_axis_if.tready = 1'b0;
        exp_drops = 0;
        in_xfer = 1'b0;
        mon_en = 1'b1;
        add_notify(16'd21, 16'd300, 1'b0);
        run_scenario();
        check_val("req034_after_err", {31'd0, stat_err}, 0);

        // Randomised notifies with stalls on every port.
        stall_pct = 40;
        for (int i = 0; i < N_RAND; i++) begin
            r = int'($urandom_range(99));
            if (r < 2) begin
                len = 16'($urandom_range(1, 300));
                add_notify(16'($urandom()), len, 1'b1);
            end else if (r < 4) begin
                add_notify(16'($urandom()), 16'd0, 1'b0);
            end else if (r < 6) begin
                len = 16'($urandom_range(4097, 9000));
                add_notify(16'($urandom()), len, 1'b0);
            end else begin
                len = 16'($urandom_range(1, 300));
                add_notify(16'($urandom()), len, 1'b0);
            end
        end
        run_scenario();
        check_val("rand_drops", stat_drop_cnt, exp_drops);
        check_val("rand_err", {31'd0, stat_err}, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tcp_rx_reader.md
TCP_RX_READER -- requirements
Module: tcp_rx_reader

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 Parameter MAX_RD_BYTES, default 4096, maximum bytes requested per rd_pkg; legal range 64..65535.
REQ-003 Port aclk, input, 1, the only clock.
REQ-004 Port areset, input, 1, asynchronous active-high reset.
REQ-005 Port s_tcp_notify (metaIntf.s), 88, notify: sid[15:0], len[31:16], ip[63:32], port[79:64], closed[80], rest reserved.
REQ-006 Port m_tcp_rd_pkg (metaIntf.m), 40, read request: sid[15:0], len[31:16], zero above.
REQ-007 Port s_tcp_rx_meta (metaIntf.s), 40, network rx meta: sid[15:0], len[31:16].
REQ-008 Port s_axis_tcp_rx (AXI4S.s), 512 data, 64 keep, tlast; payload from network.
REQ-009 Port m_rx_meta (metaIntf.m), 40, user meta: sid[15:0], len[31:16].
REQ-010 Port m_axis_rx (AXI4S.m), 512/64/tlast, payload to user.
REQ-011 Port stat_drop_cnt, output, 32, notifies dropped; stat_err, output, 1, sticky length mismatch.

Function
REQ-012 FSM states IDLE, REQ, META, DATA; one transaction in flight at a time.
REQ-013 IDLE: s_tcp_notify.ready=1; on handshake with len!=0 and closed=0, latch sid, set rem=len, go REQ.
REQ-014 IDLE: a notify with len==0 or closed=1 SHALL be consumed, stay IDLE, increment stat_drop_cnt (saturating at 2^32-1).
REQ-015 REQ: m_tcp_rd_pkg.valid=1, len=min(rem, MAX_RD_BYTES), data stable until ready; on handshake go META, rem -= chunk.
REQ-016 META: s_tcp_rx_meta.ready = m_rx_meta.ready; pass-through combinational of valid/data; on handshake latch expected byte count exp=meta.len, clear byte counter, go DATA.
REQ-017 DATA: s_axis_tcp_rx passes beat-for-beat to m_axis_rx (tready/tvalid combinational pass-through, zero latency); byte counter += popcount(tkeep) per handshake beat.
REQ-018 DATA: on tlast handshake, if counter+popcount(tkeep) != exp set stat_err; then go REQ if rem!=0 else IDLE.
REQ-019 Outside DATA, s_axis_tcp_rx.tready=0 and m_axis_rx.tvalid=0; outside META, s_tcp_rx_meta.ready=0 and m_rx_meta.valid=0.
REQ-020 rem and counters 17 bits wide internally; chunk arithmetic SHALL never underflow.
REQ-021 A new notify arriving while not IDLE SHALL be back-pressured (ready=0), never lost.
REQ-022 stat_err cleared only by reset.

Reset
REQ-023 On areset assertion, at any state, FSM->IDLE, all valid/ready outputs 0, stat_drop_cnt=0, stat_err=0, rem/counters=0, immediately (asynchronous).
REQ-024 After deassertion, s_tcp_notify.ready SHALL be 1 from the first clock edge.
REQ-025 Reset mid-DATA SHALL abandon the transfer; no partial beat is forwarded after release.

Structure
REQ-026 Field offsets, widths (notify 88, meta 40, data 512) and the FSM state enum SHALL live in lynxTypes.
REQ-027 One sub-module, tcp_rx_bytecnt (popcount of tkeep plus accumulator), is natural; all else in tcp_rx_reader.
REQ-028 Block sits directly downstream of the TCP register-slice stage, consuming its notify, rx_meta and rx data outputs.

Verification
REQ-029 Notify sid=5 len=100 -> one rd_pkg {sid 5, len 100}; meta {5,100}; 2 beats (64 + 36 keep bits) forwarded; stat_err=0; back to IDLE.
REQ-030 MAX_RD_BYTES=4096, notify len=10000 -> rd_pkg lens 4096, 4096, 1808 in order, each after prior tlast.
REQ-031 Notify len=0, then closed=1 len=50 -> no rd_pkg; stat_drop_cnt=2.
REQ-032 Meta len=128, data 1 beat with full keep + tlast -> stat_err=1, FSM returns IDLE.
REQ-033 Random tready/tvalid stalls on all ports over 1000 notifies -> byte-exact data and order, no loss, no duplication.
REQ-034 areset pulse during second DATA beat -> all outputs 0 within same cycle, drop count 0, next notify processed normally.
